// File: rtl/slip_pkg.sv
// Shared SLIP definitions: framing constants, encoder state encoding and a
// helper that flags bytes needing an escape sequence.
package slip_pkg;

    localparam logic [7:0] END     = 8'hC0;
    localparam logic [7:0] ESC     = 8'hDB;
    localparam logic [7:0] ESC_END = 8'hDC;
    localparam logic [7:0] ESC_ESC = 8'hDD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_ESC  = 2'd2,
        ST_TAIL = 2'd3
    } slip_state_t;

    function automatic logic slip_is_special(input logic [7:0] b);
        return (b == END) || (b == ESC);
    endfunction

endpackage

// File: rtl/slip_tx.sv
// SLIP frame encoder: raw bytes with an end-of-frame flag in, END/ESC framed
// bytes out through a single output register with rdy/ack handshakes.
module slip_tx
    import slip_pkg::*;
#(
    parameter int LEAD_END = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] din,
    input  logic       din_last,
    input  logic       din_rdy,
    output logic       din_ack,
    output logic [7:0] dout,
    output logic       dout_rdy,
    input  logic       dout_ack,
    output logic       busy
);

    slip_state_t state_reg;
    logic [7:0]  dout_reg;
    logic        dout_rdy_reg;
    logic [7:0]  code_reg;
    logic        last_reg;

    logic ld;
    logic body_like;

    // The output register can take a new byte when empty or being drained
    // on this very edge, so consume and load overlap without a bubble.
    assign ld        = !dout_rdy_reg | dout_ack;
    assign body_like = (state_reg == ST_BODY) ||
                       ((state_reg == ST_IDLE) && (LEAD_END == 0));
    assign din_ack   = nrst & ld & body_like;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg    <= ST_IDLE;
            dout_reg     <= 8'h00;
            dout_rdy_reg <= 1'b0;
            code_reg     <= 8'h00;
            last_reg     <= 1'b0;
        end else if (ld) begin
            dout_rdy_reg <= 1'b0;
            if (body_like) begin
                if (din_rdy) begin
                    dout_rdy_reg <= 1'b1;
                    if (slip_is_special(din)) begin
                        dout_reg  <= ESC;
                        code_reg  <= (din == END) ? ESC_END : ESC_ESC;
                        last_reg  <= din_last;
                        state_reg <= ST_ESC;
                    end else begin
                        dout_reg  <= din;
                        state_reg <= din_last ? ST_TAIL : ST_BODY;
                    end
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        // Lead END goes out first; the data byte waits.
                        if (din_rdy) begin
                            dout_reg     <= END;
                            dout_rdy_reg <= 1'b1;
                            state_reg    <= ST_BODY;
                        end
                    end
                    ST_ESC: begin
                        dout_reg     <= code_reg;
                        dout_rdy_reg <= 1'b1;
                        state_reg    <= last_reg ? ST_TAIL : ST_BODY;
                    end
                    ST_TAIL: begin
                        dout_reg     <= END;
                        dout_rdy_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign dout     = dout_reg;
    assign dout_rdy = dout_rdy_reg;
    assign busy     = (state_reg != ST_IDLE) | dout_rdy_reg;

endmodule
